// File: rtl/reg_file_alu_pkg.sv
// reg_file_alu_pkg: shared opcode encoding for the register-file/ALU pipeline
package reg_file_alu_pkg;
   localparam int OP_W = 3;
   typedef enum logic [OP_W-1:0] {
      OP_PASS_A = 3'b000,
      OP_PASS_B = 3'b001,
      OP_ADD    = 3'b010,
      OP_SUB    = 3'b011,
      OP_AND    = 3'b100,
      OP_OR     = 3'b101,
      OP_XOR    = 3'b110,
      OP_SHL    = 3'b111
   } alu_op_t;
endpackage

// File: rtl/reg_file_alu_pipe_alu_core.sv
// alu_core: combinational 8-operation ALU with Z/N/C/V flags
module alu_core
   import reg_file_alu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  alu_op_t           op,
   output logic [DATA_W-1:0] y,
   output logic              z,
   output logic              n,
   output logic              c,
   output logic              v
);
   logic [DATA_W-1:0]   w_bx;
   logic [DATA_W:0]     w_sum;
   logic [2*DATA_W-1:0] w_shl;
   logic                w_arith;
   always_comb begin
      w_bx    = (op == OP_SUB) ? ~b : b;
      w_sum   = {1'b0, a} + {1'b0, w_bx} + {{DATA_W{1'b0}}, op == OP_SUB};
      // the bit landing just above the word is the last one shifted out
      w_shl   = {{DATA_W{1'b0}}, a} << b[2:0];
      w_arith = (op == OP_ADD) || (op == OP_SUB);
      case (op)
         OP_PASS_A: y = a;
         OP_PASS_B: y = b;
         OP_ADD,
         OP_SUB:    y = w_sum[DATA_W-1:0];
         OP_AND:    y = a & b;
         OP_OR:     y = a | b;
         OP_XOR:    y = a ^ b;
         OP_SHL:    y = w_shl[DATA_W-1:0];
         default:   y = '0;
      endcase
      z = (y == '0);
      n = y[DATA_W-1];
      c = w_arith ? w_sum[DATA_W] : (op == OP_SHL) ? w_shl[DATA_W] : 1'b0;
      v = w_arith && (a[DATA_W-1] == w_bx[DATA_W-1]) && (w_sum[DATA_W-1] != a[DATA_W-1]);
   end
endmodule

// File: rtl/reg_file_alu_pipe.sv
// reg_file_alu_pipe: register file feeding a 2-stage ALU pipeline with
// optional write-back and a one-deep bypass from stage 2 into stage 1.
module reg_file_alu_pipe
   import reg_file_alu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   input  logic [ADDR_W-1:0] rd,
   input  logic [DATA_W-1:0] imm,
   input  logic              alu_src,
   input  alu_op_t           alu_op,
   input  logic              wb_en,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   output logic              flag_z,
   output logic              flag_n,
   output logic              flag_c,
   output logic              flag_v
);
   localparam int DEPTH = 2**ADDR_W;
   logic [DATA_W-1:0] r_rf [DEPTH];
   logic [DATA_W-1:0] r_a, r_b;
   logic [ADDR_W-1:0] r_rd;
   logic              r_wb, r_v1;
   alu_op_t           r_op;
   logic [DATA_W-1:0] w_y, w_a, w_b;
   logic              w_z, w_n, w_c, w_v, w_wr;
   assign w_wr = r_v1 && r_wb;
   // the write landing at this edge is not yet in the array, so forward it
   assign w_a  = (w_wr && rs1 == r_rd) ? w_y : r_rf[rs1];
   assign w_b  = alu_src ? imm : (w_wr && rs2 == r_rd) ? w_y : r_rf[rs2];
   alu_core #(.DATA_W(DATA_W)) u_alu (
      .a(r_a), .b(r_b), .op(r_op), .y(w_y), .z(w_z), .n(w_n), .c(w_c), .v(w_v)
   );
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_rd         <= '0;
         r_wb         <= 1'b0;
         r_op         <= OP_PASS_A;
         r_v1         <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
         flag_z       <= 1'b0;
         flag_n       <= 1'b0;
         flag_c       <= 1'b0;
         flag_v       <= 1'b0;
      end else begin
         r_a          <= w_a;
         r_b          <= w_b;
         r_rd         <= rd;
         r_wb         <= wb_en;
         r_op         <= alu_op;
         r_v1         <= in_valid;
         result_valid <= r_v1;
         if (r_v1) begin
            result <= w_y;
            flag_z <= w_z;
            flag_n <= w_n;
            flag_c <= w_c;
            flag_v <= w_v;
         end
         if (w_wr) r_rf[r_rd] <= w_y;
      end
   end
endmodule

// File: tb/tb_reg_file_alu_pipe.sv
// tb_reg_file_alu_pipe: table vectors, directed pipeline corner cases and
// random traffic checked against a sequential architectural model.
module tb_reg_file_alu_pipe;
   import reg_file_alu_pkg::*;
   logic       clk = 0, reset = 0, in_valid = 0, alu_src = 0, wb_en = 0;
   logic [3:0] rs1 = 0, rs2 = 0, rd = 0;
   logic [7:0] imm = 0;
   alu_op_t    alu_op = OP_PASS_A;
   logic [7:0] result;
   logic       result_valid, flag_z, flag_n, flag_c, flag_v;

   reg_file_alu_pipe #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
      .imm(imm), .alu_src(alu_src), .alu_op(alu_op), .wb_en(wb_en),
      .result(result), .result_valid(result_valid),
      .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
   );

   always #5 clk = ~clk;

   typedef struct { bit vld; int y; bit z, n, c, v; } ex_t;
   typedef struct { int op; int a; int b; int y; bit z, n, c, v; } vec_t;

   int   n_chk = 0, n_fail = 0;
   int   mem [16];
   ex_t  pend, held;
   vec_t tbl [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int sgn(int x);
      return x > 127 ? x - 256 : x;
   endfunction

   function automatic ex_t ref_alu(int op, int a, int b);
      ex_t e;
      int  r, s, sh;
      e = '{default: 0};
      e.vld = 1;
      r = 0;
      case (op)
         0: r = a;
         1: r = b;
         2: begin r = a + b; e.c = r > 255; s = sgn(a) + sgn(b); e.v = s > 127 || s < -128; end
         3: begin r = a - b; e.c = a >= b; s = sgn(a) - sgn(b); e.v = s > 127 || s < -128; end
         4: r = a & b;
         5: r = a | b;
         6: r = a ^ b;
         default: begin sh = b % 8; r = a << sh; e.c = sh != 0 && ((a >> (8 - sh)) & 1) != 0; end
      endcase
      e.y = r & 255;
      e.z = e.y == 0;
      e.n = e.y > 127;
      return e;
   endfunction

   task automatic model_reset();
      foreach (mem[i]) mem[i] = 0;
      pend = '{default: 0};
      held = '{default: 0};
   endtask

   // One cycle: present an op, clock it in, then check the op issued a cycle earlier.
   task automatic step(input bit v, input int a1, input int a2, input int d, input int im,
                       input bit src, input int op, input bit wb);
      ex_t nxt;
      in_valid = v; rs1 = a1[3:0]; rs2 = a2[3:0]; rd = d[3:0]; imm = im[7:0];
      alu_src = src; alu_op = alu_op_t'(op[2:0]); wb_en = wb;
      nxt = '{default: 0};
      if (v) begin
         nxt = ref_alu(op, mem[a1], src ? im : mem[a2]);
         if (wb) mem[d] = nxt.y;
      end
      @(posedge clk);
      #1;
      chk("result_valid", result_valid, pend.vld);
      if (pend.vld) held = pend;
      chk("result", result, held.y);
      chk("flag_z", flag_z, held.z);
      chk("flag_n", flag_n, held.n);
      chk("flag_c", flag_c, held.c);
      chk("flag_v", flag_v, held.v);
      pend = nxt;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      tbl[0]  = '{2, 'hFF, 'h01, 'h00, 1, 0, 1, 0};
      tbl[1]  = '{2, 'h7F, 'h01, 'h80, 0, 1, 0, 1};
      tbl[2]  = '{3, 'h04, 'h05, 'hFF, 0, 1, 0, 0};
      tbl[3]  = '{7, 'h81, 'h01, 'h02, 0, 0, 1, 0};
      tbl[4]  = '{3, 'h05, 'h04, 'h01, 0, 0, 1, 0};
      tbl[5]  = '{2, 'h05, 'h04, 'h09, 0, 0, 0, 0};
      tbl[6]  = '{4, 'hF0, 'h3C, 'h30, 0, 0, 0, 0};
      tbl[7]  = '{5, 'hF0, 'h0F, 'hFF, 0, 1, 0, 0};
      tbl[8]  = '{6, 'hAA, 'hAA, 'h00, 1, 0, 0, 0};
      tbl[9]  = '{7, 'h01, 'h00, 'h01, 0, 0, 0, 0};
      tbl[10] = '{3, 'h80, 'h01, 'h7F, 0, 0, 1, 1};
      tbl[11] = '{0, 'h3C, 'h99, 'h3C, 0, 0, 0, 0};

      #2 reset = 1;
      #1;
      chk("rst_result", result, 0);
      chk("rst_valid", result_valid, 0);
      chk("rst_z", flag_z, 0);
      chk("rst_n", flag_n, 0);
      chk("rst_c", flag_c, 0);
      chk("rst_v", flag_v, 0);
      @(posedge clk);
      #1 reset = 0;
      model_reset();

      for (int r = 0; r < 16; r++) step(1, r, 0, 0, 0, 0, 0, 0);
      idle();
      chk("idle_z", flag_z, 1);

      step(1, 0, 0, 5, 5, 1, 1, 1);
      step(1, 0, 0, 4, 4, 1, 1, 1);
      step(1, 5, 4, 0, 0, 0, 2, 0);
      step(1, 5, 4, 0, 0, 0, 3, 0);
      chk("ld_add", result, 'h09);
      chk("ld_add_c", flag_c, 0);
      idle();
      chk("ld_sub", result, 'h01);
      chk("ld_sub_c", flag_c, 1);

      foreach (tbl[i]) begin
         step(1, 0, 0, 10, tbl[i].a, 1, 1, 1);
         step(1, 10, 0, 11, tbl[i].b, 1, tbl[i].op, 0);
         idle();
         chk($sformatf("tbl%0d_y", i), result, tbl[i].y);
         chk($sformatf("tbl%0d_zncv", i), {flag_z, flag_n, flag_c, flag_v},
             {tbl[i].z, tbl[i].n, tbl[i].c, tbl[i].v});
      end

      step(1, 0, 0, 1, 3, 1, 1, 1);
      step(1, 1, 1, 1, 0, 0, 2, 1);
      chk("byp_1", result, 3);
      step(1, 1, 1, 2, 0, 0, 2, 1);
      chk("byp_2", result, 6);
      idle();
      chk("byp_3", result, 12);

      step(0, 0, 0, 7, 'hAA, 1, 1, 1);
      step(1, 7, 0, 0, 0, 0, 0, 0);
      chk("gate_valid", result_valid, 0);
      idle();
      chk("gate_r7", result, 0);

      step(1, 0, 0, 3, 'h55, 1, 1, 1);
      idle();
      in_valid = 1; rs1 = 3; rs2 = 3; rd = 3; alu_src = 0; alu_op = OP_ADD; wb_en = 1;
      @(posedge clk);
      #2 in_valid = 0; wb_en = 0; reset = 1;
      #1 chk("mid_rst_valid0", result_valid, 0);
      @(posedge clk);
      #1 chk("mid_rst_valid1", result_valid, 0);
      reset = 0;
      model_reset();
      step(1, 3, 0, 0, 0, 0, 0, 0);
      idle();
      chk("mid_rst_r3", result, 0);

      for (int k = 0; k < 400; k++)
         step($urandom_range(3) != 0, $urandom_range(15), $urandom_range(15), $urandom_range(15),
              $urandom_range(255), $urandom_range(1), $urandom_range(7), $urandom_range(1));
      idle();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
